// File: rtl/shift_arbiter.sv
// Round-robin arbiter that lends one external combinational shifter to two requesters.
// A request is accepted in IDLE, its operands drive the shifter in ISSUE, and the result is held in HOLD until it is acknowledged.
module shift_arbiter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_in,
  input  logic [1:0]         req0_op,
  input  logic [SHAMT_W-1:0] req0_amt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_in,
  input  logic [1:0]         req1_op,
  input  logic [SHAMT_W-1:0] req1_amt,
  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [WIDTH-1:0]   resp_result,
  output logic [WIDTH-1:0]   sh_in,
  output logic [1:0]         sh_op,
  output logic [SHAMT_W-1:0] sh_amt,
  input  logic [WIDTH-1:0]   sh_result,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     op_in_q, op_in_d;
  logic [1:0]           op_op_q, op_op_d;
  logic [SHAMT_W-1:0]   op_amt_q, op_amt_d;
  logic                 owner_q, owner_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 winner;
  logic                 pass_thru;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_in_q  <= '0;
      op_op_q  <= '0;
      op_amt_q <= '0;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_in_q  <= op_in_d;
      op_op_q  <= op_op_d;
      op_amt_q <= op_amt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      result_q <= result_d;
    end
  end

  // A lone valid requester wins outright; rr_ptr only breaks ties.
  assign winner = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;

  always_comb begin
    state_d    = state_q;
    op_in_d    = op_in_q;
    op_op_d    = op_op_q;
    op_amt_d   = op_amt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    result_d   = result_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = req0_valid && !winner;
        req1_ready = req1_valid && winner;
        if (req0_valid || req1_valid) begin
          op_in_d  = winner ? req1_in  : req0_in;
          op_op_d  = winner ? req1_op  : req0_op;
          op_amt_d = winner ? req1_amt : req0_amt;
          owner_d  = winner;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        result_d = sh_result;
        state_d  = HOLD;
      end
      HOLD: begin
        if (owner_q ? resp1_ready : resp0_ready) begin
          rr_ptr_d = ~owner_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pass-through is a zero-distance logical right shift, so the shifter's op 3 is never used.
  assign pass_thru   = (op_op_q == 2'd3);
  assign sh_in       = op_in_q;
  assign sh_op       = pass_thru ? 2'd0 : op_op_q;
  assign sh_amt      = pass_thru ? '0 : op_amt_q;
  assign resp_result = result_q;
  assign resp0_valid = (state_q == HOLD) && !owner_q;
  assign resp1_valid = (state_q == HOLD) && owner_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (one job in flight, result ready one cycle after accept).
module tb_shift_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_in = '0, req1_in = '0;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [4:0]  req0_amt = '0, req1_amt = '0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [31:0] resp_result, sh_in, sh_result;
  logic [1:0]  sh_op;
  logic [4:0]  sh_amt;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  shift_arbiter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
    .req0_op(req0_op), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
    .req1_op(req1_op), .req1_amt(req1_amt),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result),
    .sh_in(sh_in), .sh_op(sh_op), .sh_amt(sh_amt), .sh_result(sh_result),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // External shifter; op 3 returns junk so an unmapped pass-through is visible.
  always_comb begin
    case (sh_op)
      2'd0:    sh_result = sh_in >> sh_amt;
      2'd1:    sh_result = $unsigned($signed(sh_in) >>> sh_amt);
      2'd2:    sh_result = sh_in << sh_amt;
      default: sh_result = ~sh_in;
    endcase
  end

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [1:0] op,
                                         input logic [4:0] n);
    logic [63:0] ext;
    case (op)
      2'd0: return a / (32'd1 << n);
      2'd1: begin
        ext = {{32{a[31]}}, a};
        return ext[n +: 32];
      end
      2'd2: return a * (32'd1 << n);
      default: return a;
    endcase
  endfunction

  // Transaction model
  bit          m_busy, m_owner, m_pri, m_done_issue, acc0, acc1;
  logic [31:0] m_in, m_res;
  logic [1:0]  m_op;
  logic [4:0]  m_amt;
  logic [31:0] last_res0, last_res1;
  int          grants[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_pri = 0; m_done_issue = 0;
    m_in = '0; m_op = '0; m_amt = '0; m_res = '0;
    acc0 = 0; acc1 = 0;
  endtask

  task automatic check_zero_outputs();
    check_eq("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    check_eq("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
    check_eq("rst_resp0_valid", {31'b0, resp0_valid}, 32'd0);
    check_eq("rst_resp1_valid", {31'b0, resp1_valid}, 32'd0);
    check_eq("rst_resp_result", resp_result, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_sh_in", sh_in, 32'd0);
    check_eq("rst_sh_op", {30'b0, sh_op}, 32'd0);
    check_eq("rst_sh_amt", {27'b0, sh_amt}, 32'd0);
  endtask

  // Called one time unit after a rising edge; asserts reset mid-cycle.
  task automatic async_reset();
    req0_valid = 0; req1_valid = 0;
    #5 reset = 1'b1;
    #1 check_zero_outputs();
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // One clock cycle with the inputs currently driven: compare at the falling edge, advance model at the rising edge.
  task automatic step();
    bit exp_r0, exp_r1, w;
    @(negedge clock);
    exp_r0 = !m_busy && req0_valid && (!req1_valid || !m_pri);
    exp_r1 = !m_busy && req1_valid && (!req0_valid || m_pri);
    check_eq("req0_ready", {31'b0, req0_ready}, {31'b0, exp_r0});
    check_eq("req1_ready", {31'b0, req1_ready}, {31'b0, exp_r1});
    check_eq("resp0_valid", {31'b0, resp0_valid}, {31'b0, m_busy && m_done_issue && !m_owner});
    check_eq("resp1_valid", {31'b0, resp1_valid}, {31'b0, m_busy && m_done_issue && m_owner});
    check_eq("resp_result", resp_result, m_res);
    check_eq("busy", {31'b0, busy}, {31'b0, m_busy});
    check_eq("sh_in", sh_in, m_in);
    check_eq("sh_op", {30'b0, sh_op}, (m_op == 2'd3) ? 32'd0 : {30'b0, m_op});
    check_eq("sh_amt", {27'b0, sh_amt}, (m_op == 2'd3) ? 32'd0 : {27'b0, m_amt});
    if (resp0_valid) last_res0 = resp_result;
    if (resp1_valid) last_res1 = resp_result;
    if (req0_valid && req0_ready) grants.push_back(0);
    if (req1_valid && req1_ready) grants.push_back(1);
    @(posedge clock);
    acc0 = 0; acc1 = 0;
    if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        w = (req0_valid && req1_valid) ? m_pri : req1_valid;
        m_in  = w ? req1_in  : req0_in;
        m_op  = w ? req1_op  : req0_op;
        m_amt = w ? req1_amt : req0_amt;
        m_owner = w; m_busy = 1; m_done_issue = 0;
        acc0 = !w; acc1 = w;
      end
    end else if (!m_done_issue) begin
      m_res = ref_op(m_in, m_op, m_amt);
      m_done_issue = 1;
    end else if (m_owner ? resp1_ready : resp0_ready) begin
      m_busy = 0; m_pri = !m_owner;
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    #6 async_reset();

    // Single SRA from requester 0
    resp0_ready = 1; resp1_ready = 1;
    req0_valid = 1; req0_in = 32'h8000_0010; req0_op = 2'd1; req0_amt = 5'd4;
    step();
    req0_valid = 0;
    steps(3);
    check_eq("sra_result", last_res0, 32'hF800_0001);

    // Contention from reset with immediate acknowledge
    async_reset();
    grants.delete();
    req0_in = 32'h0000_0001; req0_op = 2'd2; req0_amt = 5'd31;
    req1_in = 32'h8000_0000; req1_op = 2'd0; req1_amt = 5'd31;
    req0_valid = 1; req1_valid = 1;
    steps(13);
    req0_valid = 0; req1_valid = 0;
    steps(3);
    check_eq("contention_ngrants", grants.size() >= 4 ? 32'd1 : 32'd0, 32'd1);
    if (grants.size() >= 4)
      for (int i = 0; i < 4; i++)
        check_eq($sformatf("grant_order%0d", i), grants[i], i % 2);
    check_eq("sll31_result", last_res0, 32'h8000_0000);
    check_eq("srl31_result", last_res1, 32'h0000_0001);

    // Backpressure on requester 1 while requester 0 waits
    grants.delete();
    resp1_ready = 0;
    req1_valid = 1; req1_in = 32'h1234_5678; req1_op = 2'd1; req1_amt = 5'd8;
    step();
    req1_valid = 0;
    req0_valid = 1; req0_in = 32'hCAFE_F00D; req0_op = 2'd0; req0_amt = 5'd3;
    steps(11);
    check_eq("bp_no_grant", grants.size(), 32'd1);
    resp1_ready = 1;
    step();
    step();
    check_eq("bp_then_grant0", grants.size() == 2 ? grants[1] : 32'hFFFF_FFFF, 32'd0);
    req0_valid = 0;
    steps(3);

    // Pass-through and zero-amount shift
    req0_valid = 1; req0_in = 32'hDEAD_BEEF; req0_op = 2'd3; req0_amt = 5'd7;
    step();
    req0_valid = 0;
    check_eq("pass_sh_op", {30'b0, sh_op}, 32'd0);
    check_eq("pass_sh_amt", {27'b0, sh_amt}, 32'd0);
    steps(3);
    check_eq("pass_result", last_res0, 32'hDEAD_BEEF);
    req1_valid = 1; req1_in = 32'h0F0F_1234; req1_op = 2'd2; req1_amt = 5'd0;
    step();
    req1_valid = 0;
    steps(3);
    check_eq("sll0_result", last_res1, 32'h0F0F_1234);

    // Reset during ISSUE drops the request
    req0_valid = 1; req0_in = 32'hAAAA_5555; req0_op = 2'd0; req0_amt = 5'd1;
    step();
    async_reset();
    steps(4);
    // Reset during HOLD, with rr_ptr pointing at requester 1 beforehand
    req0_valid = 1; req0_in = 32'h0000_00F0; req0_op = 2'd0; req0_amt = 5'd4;
    step();
    req0_valid = 0;
    steps(3);
    req1_valid = 1; req1_in = 32'h5555_0000; req1_op = 2'd2; req1_amt = 5'd2;
    step();
    req1_valid = 0;
    step();
    async_reset();
    grants.delete();
    req0_valid = 1; req1_valid = 1;
    step();
    check_eq("post_reset_grant0", grants.size() == 1 ? grants[0] : 32'hFFFF_FFFF, 32'd0);
    req0_valid = 0;
    req1_valid = 1;
    steps(4);
    req1_valid = 0;
    steps(3);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      if (req0_valid && !acc0) begin
        if ($urandom_range(7) == 0) req0_valid = 0;
      end else begin
        req0_valid = $urandom_range(1);
        req0_in = $urandom; req0_op = 2'($urandom_range(3));
        req0_amt = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
      end
      if (req1_valid && !acc1) begin
        if ($urandom_range(7) == 0) req1_valid = 0;
      end else begin
        req1_valid = $urandom_range(1);
        req1_in = $urandom; req1_op = 2'($urandom_range(3));
        req1_amt = ($urandom_range(3) == 0) ? 5'd31 : 5'($urandom_range(31));
      end
      resp0_ready = $urandom_range(1);
      resp1_ready = $urandom_range(1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
